// File: rtl/tile_pkg.sv
// Shared definitions for the piano-tiles sequencer.
// - STEPS / LANES / IDX_W : pattern geometry and index width
// - state_t               : sequencer FSM states (IDLE=0, PLAY=1, PAUSE=2, DONE=3)
// - LANE1..LANE4          : lane note patterns. Step 0 is the MSB and step k
//                           is bit [STEPS-1-k]. A 1 bit means a tile is present.
package tile_pkg;

   localparam int STEPS = 72;
   localparam int LANES = 4;
   localparam int IDX_W = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Mostly a lane staircase. Lane 4 also carries a tile on step 0,
   // so the first row is a two-tile chord.
   localparam logic [STEPS-1:0] LANE1 = 72'h88_8888_8888_8888_8888;
   localparam logic [STEPS-1:0] LANE2 = 72'h44_4444_4444_4444_4444;
   localparam logic [STEPS-1:0] LANE3 = 72'h22_2222_2222_2222_2222;
   localparam logic [STEPS-1:0] LANE4 = 72'h91_1111_1111_1111_1111;

endpackage

// File: rtl/tile_sequencer_if.sv
// Row bus from the sequencer to the downstream tile shifter/display.
// - row_valid : a lane pattern is pending on row
// - row       : row[0]=lane1 .. row[3]=lane4, 1 = tile present
// - row_ready : the consumer accepts the row this cycle
// Handshake: a transfer happens on a rising clock edge where row_valid and
// row_ready are both high. Once row_valid is raised, row_valid and row are
// held unchanged until that transfer. row_ready may change freely and does
// not depend on row_valid.
interface tile_sequencer_if;
   import tile_pkg::*;

   logic             row_valid;
   logic             row_ready;
   logic [LANES-1:0] row;

   modport master (output row_valid, output row, input row_ready);
   modport slave  (input row_valid, input row, output row_ready);

endinterface

// File: rtl/tile_pattern_rom.sv
// Combinational note-pattern lookup: step index -> one row of lane bits.
// - index : step number, 0 .. STEPS-1
// - row   : row[0]=lane1 .. row[3]=lane4
module tile_pattern_rom
   import tile_pkg::*;
(
   input  logic [IDX_W-1:0] index,
   output logic [LANES-1:0] row
);

   logic [IDX_W-1:0] pos;

   // Step 0 lives in the MSB of every lane vector.
   always_comb begin
      pos = IDX_W'(STEPS - 1) - index;
      row = {LANE4[pos], LANE3[pos], LANE2[pos], LANE1[pos]};
   end

endmodule

// File: rtl/tile_sequencer.sv
// Game-play controller: steps through the lane pattern and issues one row
// per beat over a valid/ready row bus.
// - CLOCK_50  : system clock, rising edge
// - resetn    : asynchronous active-low reset
// - start     : 1-cycle pulse, (re)starts the song at step 0 from IDLE or DONE
// - pause     : level, holds beat progress while high
// - loop_en   : level, wrap to step 0 at end of song instead of finishing
// - speed     : beat divisor = TICK_DIV >> speed
// - row_bus   : row handshake (master side)
// - index     : step number of the current/next row
// - busy/done : high in PLAY or PAUSE / high in DONE
// - state     : FSM state, debug visibility
// - tick_cnt  : beat prescaler count, debug visibility
// TICK_DIV must be >= 8 so that speed 3 still divides by at least 1.
module tile_sequencer
   import tile_pkg::*;
#(
   parameter  int TICK_DIV = 8,
   localparam int CNT_W    = $clog2(TICK_DIV)
)(
   input  logic             CLOCK_50,
   input  logic             resetn,
   input  logic             start,
   input  logic             pause,
   input  logic             loop_en,
   input  logic [1:0]       speed,
   tile_sequencer_if.master row_bus,
   output logic [IDX_W-1:0] index,
   output logic             busy,
   output logic             done,
   output state_t           state,
   output logic [CNT_W-1:0] tick_cnt
);

   localparam logic [CNT_W:0] DIV_BASE = (CNT_W + 1)'(TICK_DIV);
   localparam logic [CNT_W:0] DIV_ONE  = (CNT_W + 1)'(1);

   state_t           state_d;
   logic [CNT_W:0]   div;
   logic [CNT_W:0]   div_m1;
   logic             count_en;
   logic             beat;
   logic             xfer;
   logic             last_step;
   logic             restart;
   logic [LANES-1:0] rom_row;

   tile_pattern_rom u_rom (
      .index (index),
      .row   (rom_row)
   );

   // Beat generation. The >= compare makes a mid-beat switch to a faster
   // speed fire immediately instead of wrapping past the new terminal count.
   // A pending row freezes the prescaler, so backpressure stretches the beat.
   always_comb begin
      div       = DIV_BASE >> speed;
      div_m1    = div - DIV_ONE;
      count_en  = (state == PLAY) && !row_bus.row_valid && !pause;
      beat      = count_en && ({1'b0, tick_cnt} >= div_m1);
      xfer      = row_bus.row_valid && row_bus.row_ready;
      last_step = (index == IDX_W'(STEPS - 1));
      restart   = start && ((state == IDLE) || (state == DONE));
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_d;
   end

   // A pending row may still be taken while paused, so the end-of-song
   // check is made in PAUSE as well as PLAY and takes priority over pause.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:  if (restart) state_d = PLAY;
         PLAY: begin
            if (xfer && last_step && !loop_en) state_d = DONE;
            else if (pause)                    state_d = PAUSE;
         end
         PAUSE: begin
            if (xfer && last_step && !loop_en) state_d = DONE;
            else if (!pause)                   state_d = PLAY;
         end
         DONE:  if (restart) state_d = PLAY;
         default: state_d = IDLE;
      endcase
   end

   // Prescaler, step index and row register. beat and xfer never coincide
   // because a beat requires row_valid low.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         tick_cnt          <= '0;
         index             <= '0;
         row_bus.row_valid <= 1'b0;
         row_bus.row       <= '0;
      end else if (restart) begin
         tick_cnt <= '0;
         index    <= '0;
      end else begin
         if (beat) begin
            tick_cnt          <= '0;
            row_bus.row       <= rom_row;
            row_bus.row_valid <= 1'b1;
         end else if (count_en) begin
            tick_cnt <= tick_cnt + CNT_W'(1);
         end
         if (xfer) begin
            row_bus.row_valid <= 1'b0;
            if (!last_step)   index <= index + IDX_W'(1);
            else if (loop_en) index <= '0;
         end
      end
   end

   assign busy = (state == PLAY) || (state == PAUSE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer: reset, free-run timing, backpressure,
// pause, speed change, end of song with and without loop, reset mid-song.
module tb_tile_sequencer;
   import tile_pkg::*;

   localparam int CNT_W = 3;

   logic             CLOCK_50;
   logic             resetn;
   logic             start;
   logic             pause;
   logic             loop_en;
   logic [1:0]       speed;
   logic [IDX_W-1:0] index;
   logic             busy;
   logic             done;
   state_t           state;
   logic [CNT_W-1:0] tick_cnt;

   int checks = 0;
   int errors = 0;

   tile_sequencer_if bus ();

   tile_sequencer #(.TICK_DIV(8)) dut (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .start    (start),
      .pause    (pause),
      .loop_en  (loop_en),
      .speed    (speed),
      .row_bus  (bus),
      .index    (index),
      .busy     (busy),
      .done     (done),
      .state    (state),
      .tick_cnt (tick_cnt)
   );

   // ---------------- clock ----------------
   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // ---------------- helpers ----------------
   // Hand-derived pattern: step 0 is lanes 1+4, otherwise lane (k mod 4)+1.
   function automatic logic [3:0] exp_row(input int k);
      logic [3:0] one;
      one = 4'b0001;
      if (k == 0) return 4'b1001;
      return one << (k % 4);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; everything is driven and sampled 1 ns after the edge.
   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Tick until row_valid is seen, bounded by limit; n = ticks taken.
   task automatic wait_row(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.row_valid && n < limit);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int bad;
      int exp_idx;

      resetn        = 1'b0;
      start         = 1'b0;
      pause         = 1'b0;
      loop_en       = 1'b0;
      speed         = 2'd0;
      bus.row_ready = 1'b1;
      tick();
      tick();

      // Reset state
      chk("rst_state", 32'(state), 32'(IDLE));
      chk("rst_index", 32'(index), 32'd0);
      chk("rst_valid", 32'(bus.row_valid), 32'd0);
      chk("rst_row",   32'(bus.row), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      resetn = 1'b1;
      tick();
      chk("idle_hold", 32'(state), 32'(IDLE));

      // Free-run at speed 0: first row 9 cycles after start
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_tick", 32'(tick_cnt), 32'd0);
      wait_row(40, n);
      chk("first_lat", 32'(n + 1), 32'd9);
      chk("first_row", 32'(bus.row), 32'(exp_row(0)));
      chk("first_idx", 32'(index), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         wait_row(40, n);
         chk("run_period", 32'(n), 32'd9);
         chk("run_idx", 32'(index), 32'(k));
         chk("run_row", 32'(bus.row), 32'(exp_row(k)));
      end

      // Backpressure: row 4 held for 20 cycles
      bus.row_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.row_valid !== 1'b1 || bus.row !== exp_row(4) || index !== 7'd4) bad++;
      end
      chk("bp_stable", 32'(bad), 32'd0);
      bus.row_ready = 1'b1;
      tick();
      chk("bp_xfer_idx", 32'(index), 32'd5);
      chk("bp_xfer_valid", 32'(bus.row_valid), 32'd0);
      tick();
      chk("bp_single", 32'(index), 32'd5);
      wait_row(40, n);
      chk("bp_next_lat", 32'(n), 32'd7);
      chk("bp_next_row", 32'(bus.row), 32'(exp_row(5)));

      // Pause with tick_cnt=3 and no row pending
      tick();
      tick();
      tick();
      tick();
      chk("pz_tick_pre", 32'(tick_cnt), 32'd3);
      chk("pz_valid_pre", 32'(bus.row_valid), 32'd0);
      pause = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("pz_state", 32'(state), 32'(PAUSE));
      chk("pz_tick_frozen", 32'(tick_cnt), 32'd3);
      chk("pz_busy", 32'(busy), 32'd1);
      chk("pz_idx", 32'(index), 32'd6);
      pause = 1'b0;
      tick();
      chk("pz_resume_state", 32'(state), 32'(PLAY));
      chk("pz_resume_tick", 32'(tick_cnt), 32'd3);
      wait_row(40, n);
      chk("pz_beat_lat", 32'(n), 32'd5);
      chk("pz_row", 32'(bus.row), 32'(exp_row(6)));

      // Pause while a row is pending: transfer still completes in PAUSE
      bus.row_ready = 1'b0;
      pause         = 1'b1;
      tick();
      chk("pp_state", 32'(state), 32'(PAUSE));
      chk("pp_valid", 32'(bus.row_valid), 32'd1);
      bus.row_ready = 1'b1;
      tick();
      chk("pp_xfer_idx", 32'(index), 32'd7);
      chk("pp_xfer_valid", 32'(bus.row_valid), 32'd0);
      chk("pp_still_pause", 32'(state), 32'(PAUSE));
      pause = 1'b0;
      tick();
      chk("pp_play", 32'(state), 32'(PLAY));

      // Speed 0 -> 3 with tick_cnt=5: beat fires at once
      n = 0;
      while (tick_cnt != 3'd5 && n < 20) begin
         tick();
         n++;
      end
      chk("sp_tick5", 32'(tick_cnt), 32'd5);
      speed = 2'd3;
      tick();
      chk("sp_valid", 32'(bus.row_valid), 32'd1);
      chk("sp_row", 32'(bus.row), 32'(exp_row(7)));
      chk("sp_tick0", 32'(tick_cnt), 32'd0);
      wait_row(10, n);
      chk("sp_period_a", 32'(n), 32'd2);
      chk("sp_idx_a", 32'(index), 32'd8);
      wait_row(10, n);
      chk("sp_period_b", 32'(n), 32'd2);
      chk("sp_idx_b", 32'(index), 32'd9);

      // End of song, loop_en=0
      exp_idx = 10;
      bad = 0;
      n = 0;
      while (!done && n < 400) begin
         tick();
         n++;
         if (bus.row_valid) begin
            if (index !== 7'(exp_idx) || bus.row !== exp_row(exp_idx)) bad++;
            exp_idx++;
         end
      end
      chk("eos_seq", 32'(bad), 32'd0);
      chk("eos_count", 32'(exp_idx), 32'd72);
      chk("eos_done", 32'(done), 32'd1);
      chk("eos_idx", 32'(index), 32'd71);
      chk("eos_busy", 32'(busy), 32'd0);
      chk("eos_last_row", 32'(bus.row), 32'(exp_row(71)));
      tick();
      tick();
      tick();
      chk("eos_hold_state", 32'(state), 32'(DONE));
      chk("eos_hold_valid", 32'(bus.row_valid), 32'd0);

      // Restart from DONE, then loop through the end
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rs_state", 32'(state), 32'(PLAY));
      chk("rs_idx", 32'(index), 32'd0);
      chk("rs_done", 32'(done), 32'd0);
      loop_en = 1'b1;
      n = 0;
      while (!(bus.row_valid && index == 7'd71) && n < 400) begin
         tick();
         n++;
      end
      chk("lp_at71", 32'(index), 32'd71);
      tick();
      chk("lp_wrap_idx", 32'(index), 32'd0);
      chk("lp_state", 32'(state), 32'(PLAY));
      chk("lp_done", 32'(done), 32'd0);
      wait_row(10, n);
      chk("lp_row0", 32'(bus.row), 32'(exp_row(0)));

      // Reset mid-song at index 30 with a row pending
      n = 0;
      while (!(bus.row_valid && index == 7'd30) && n < 200) begin
         tick();
         n++;
      end
      chk("mr_pre_idx", 32'(index), 32'd30);
      chk("mr_pre_valid", 32'(bus.row_valid), 32'd1);
      resetn = 1'b0;
      #1;
      chk("mr_valid", 32'(bus.row_valid), 32'd0);
      chk("mr_idx", 32'(index), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_state", 32'(state), 32'(IDLE));
      #20;
      resetn = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
